// File: rtl/subservient_gpio_n.sv
// GPIO block with a Wishbone-style register port, pin input synchronisers and optional edge interrupts.
// Latency: ack one cycle after the request; IN lags the pins by SYNC_STAGES cycles; o_irq is one cycle behind PEND.
// Backpressure: none; the master holds i_wb_stb until ack. The interrupt logic is built only if SUBSERVIENT_GPIO_IRQ_EN is defined.
module subservient_gpio_n #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [2:0]       i_wb_adr,
    input  logic [31:0]      i_wb_dat,
    input  logic             i_wb_we,
    input  logic             i_wb_stb,
    output logic [31:0]      o_wb_rdt,
    output logic             o_wb_ack,
    input  logic [WIDTH-1:0] i_gpio,
    output logic [WIDTH-1:0] o_gpio,
    output logic [WIDTH-1:0] o_gpio_oe,
    output logic             o_irq
);

    localparam logic [2:0] ADR_OUT  = 3'd0;
    localparam logic [2:0] ADR_DIR  = 3'd1;
    localparam logic [2:0] ADR_IN   = 3'd2;
    localparam logic [2:0] ADR_MASK = 3'd3;
    localparam logic [2:0] ADR_PEND = 3'd4;

    logic                                ack_q, ack_d;
    logic [31:0]                         rdt_q, rdt_d;
    logic [WIDTH-1:0]                    out_q, out_d;
    logic [WIDTH-1:0]                    dir_q, dir_d;
    logic [SYNC_STAGES-1:0][WIDTH-1:0]   sync_q, sync_d;
    logic [WIDTH-1:0]                    gpio_in;
    logic [WIDTH-1:0]                    wdat;
    logic [WIDTH-1:0]                    rd_sel;
    logic                                wr_en;
    logic                                unused_ok;

    assign gpio_in   = sync_q[SYNC_STAGES-1];
    assign wdat      = i_wb_dat[WIDTH-1:0];
    assign unused_ok = ^i_wb_dat;

`ifdef SUBSERVIENT_GPIO_IRQ_EN
    // Edge detection stays disarmed until the synchroniser and history flops
    // hold real pin values, so pins already high at reset do not pend.
    localparam logic [2:0] ARM_CNT = 3'(SYNC_STAGES + 1);

    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [2:0]       arm_q, arm_d;
    logic             irq_q, irq_d;
    logic             armed;
    logic [WIDTH-1:0] rise;

    assign armed = (arm_q == ARM_CNT);
    assign rise  = armed ? (gpio_in & ~prev_q) : '0;

    always_comb begin
        arm_d  = armed ? arm_q : arm_q + 3'd1;
        prev_d = gpio_in;
        mask_d = mask_q;
        pend_d = pend_q;
        if (wr_en && i_wb_adr == ADR_MASK) mask_d = wdat;
        if (wr_en && i_wb_adr == ADR_PEND) pend_d = pend_q & ~wdat;
        // A fresh edge wins over a simultaneous write-1-to-clear.
        pend_d = pend_d | rise;
        irq_d  = |(pend_q & mask_q);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mask_q <= '0;
            pend_q <= '0;
            prev_q <= '0;
            arm_q  <= '0;
            irq_q  <= 1'b0;
        end else begin
            mask_q <= mask_d;
            pend_q <= pend_d;
            prev_q <= prev_d;
            arm_q  <= arm_d;
            irq_q  <= irq_d;
        end
    end

    assign o_irq = irq_q;
`else
    assign o_irq = 1'b0;
`endif

    always_comb begin
        ack_d  = i_wb_stb & ~ack_q;
        wr_en  = ack_q & i_wb_we;
        out_d  = out_q;
        dir_d  = dir_q;
        if (wr_en && i_wb_adr == ADR_OUT) out_d = wdat;
        if (wr_en && i_wb_adr == ADR_DIR) dir_d = wdat;
        sync_d = {sync_q[SYNC_STAGES-2:0], i_gpio};
        rd_sel = '0;
        case (i_wb_adr)
            ADR_OUT:  rd_sel = out_q;
            ADR_DIR:  rd_sel = dir_q;
            ADR_IN:   rd_sel = gpio_in;
`ifdef SUBSERVIENT_GPIO_IRQ_EN
            ADR_MASK: rd_sel = mask_q;
            ADR_PEND: rd_sel = pend_q;
`endif
            default:  rd_sel = '0;
        endcase
        // Read data is captured at the request cycle so it is valid exactly in the ack cycle.
        rdt_d = (i_wb_stb && !ack_q && !i_wb_we) ? 32'(rd_sel) : 32'd0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ack_q  <= 1'b0;
            rdt_q  <= '0;
            out_q  <= '0;
            dir_q  <= '0;
            sync_q <= '0;
        end else begin
            ack_q  <= ack_d;
            rdt_q  <= rdt_d;
            out_q  <= out_d;
            dir_q  <= dir_d;
            sync_q <= sync_d;
        end
    end

    assign o_wb_ack  = ack_q;
    assign o_wb_rdt  = rdt_q;
    assign o_gpio    = out_q;
    assign o_gpio_oe = dir_q;

endmodule

// File: tb/tb_subservient_gpio_n.sv
// Directed bench for subservient_gpio_n; read expectations go through a scoreboard queue.
// Interrupt expectations follow whether SUBSERVIENT_GPIO_IRQ_EN is defined for the build.
module tb_subservient_gpio_n;

    localparam int WIDTH = 8;
    localparam int SYNC  = 2;
`ifdef SUBSERVIENT_GPIO_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic [2:0]       wb_adr;
    logic [31:0]      wb_dat;
    logic             wb_we;
    logic             wb_stb;
    logic [31:0]      wb_rdt;
    logic             wb_ack;
    logic [WIDTH-1:0] gpio_in;
    logic [WIDTH-1:0] gpio_out;
    logic [WIDTH-1:0] gpio_oe;
    logic             irq;

    int          n_asserts = 0;
    int          n_fail    = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    subservient_gpio_n #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC)) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_wb_adr  (wb_adr),
        .i_wb_dat  (wb_dat),
        .i_wb_we   (wb_we),
        .i_wb_stb  (wb_stb),
        .o_wb_rdt  (wb_rdt),
        .o_wb_ack  (wb_ack),
        .i_gpio    (gpio_in),
        .o_gpio    (gpio_out),
        .o_gpio_oe (gpio_oe),
        .o_irq     (irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Starts at #1 after an edge; returns #1 after the edge that ends the ack cycle.
    task automatic wb_xfer(input string tag, input logic [2:0] adr, input logic [31:0] dat,
                           input logic we, input logic [31:0] exp_rd);
        int lat;
        wb_adr = adr;
        wb_dat = dat;
        wb_we  = we;
        wb_stb = 1'b1;
        if (!we) exp_q.push_back(exp_rd);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!wb_ack && lat < 8);
        check({tag, "_ack_lat"}, 32'(lat), 32'd1);
        if (!we && exp_q.size() > 0) check({tag, "_rdt"}, wb_rdt, exp_q.pop_front());
        @(posedge clk);
        #1;
        check({tag, "_ack_single"}, {31'd0, wb_ack}, 32'd0);
        check({tag, "_rdt_idle"}, wb_rdt, 32'd0);
        wb_stb = 1'b0;
        wb_we  = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        wb_adr  = '0;
        wb_dat  = '0;
        wb_we   = 1'b0;
        wb_stb  = 1'b0;
        gpio_in = '0;
        wait_cycles(3);
        check("rst_gpio", 32'(gpio_out), 32'd0);
        check("rst_oe", 32'(gpio_oe), 32'd0);
        check("rst_ack", {31'd0, wb_ack}, 32'd0);
        check("rst_rdt", wb_rdt, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        rst_n = 1'b1;
        wait_cycles(SYNC + 3);

        // Register write/readback, upper data bits discarded
        wb_xfer("wr_out", 3'd0, 32'hFFFF_FFA5, 1'b1, 32'd0);
        wb_xfer("wr_dir", 3'd1, 32'h0000_000F, 1'b1, 32'd0);
        check("gpio_out", 32'(gpio_out), 32'hA5);
        check("gpio_oe", 32'(gpio_oe), 32'h0F);
        wb_xfer("rd_out", 3'd0, 32'd0, 1'b0, 32'h0000_00A5);
        wb_xfer("rd_dir", 3'd1, 32'd0, 1'b0, 32'h0000_000F);
        wb_xfer("wr_adr5", 3'd5, 32'hFFFF_FFFF, 1'b1, 32'd0);
        wb_xfer("rd_adr5", 3'd5, 32'd0, 1'b0, 32'd0);
        wb_xfer("rd_adr7", 3'd7, 32'd0, 1'b0, 32'd0);
        wb_xfer("rd_out2", 3'd0, 32'd0, 1'b0, 32'h0000_00A5);
        wb_xfer("rd_mask0", 3'd3, 32'd0, 1'b0, 32'd0);

        // Input synchroniser latency and edge pending
        @(posedge clk);
        #1;
        gpio_in = 8'h3C;
        wait_cycles(SYNC - 1);
        wb_xfer("in_early", 3'd2, 32'd0, 1'b0, 32'h0);
        wb_xfer("in_late", 3'd2, 32'd0, 1'b0, 32'h3C);
        wb_xfer("pend_3c", 3'd4, 32'd0, 1'b0, IRQ_EN ? 32'h3C : 32'h0);
        check("irq_unmasked", {31'd0, irq}, 32'd0);

        // Masked interrupt on pin 2 and its clear
        gpio_in = 8'h00;
        wait_cycles(SYNC + 2);
        wb_xfer("clr_all", 3'd4, 32'hFF, 1'b1, 32'd0);
        wb_xfer("wr_mask", 3'd3, 32'h04, 1'b1, 32'd0);
        wb_xfer("pend_clr", 3'd4, 32'd0, 1'b0, 32'h0);
        check("irq_idle", {31'd0, irq}, 32'd0);
        @(posedge clk);
        #1;
        gpio_in = 8'h04;
        wait_cycles(SYNC + 1);
        check("irq_same_as_pend", {31'd0, irq}, 32'd0);
        wait_cycles(1);
        check("irq_set", {31'd0, irq}, {31'd0, IRQ_EN});
        wb_xfer("w1c_pin2", 3'd4, 32'h04, 1'b1, 32'd0);
        check("irq_before_clr", {31'd0, irq}, {31'd0, IRQ_EN});
        wait_cycles(1);
        check("irq_cleared", {31'd0, irq}, 32'd0);

        // Edge on pin 5 coinciding with its write-1-to-clear
        gpio_in = 8'h24;
        wait_cycles(SYNC + 2);
        wb_xfer("pend_pin5", 3'd4, 32'd0, 1'b0, IRQ_EN ? 32'h20 : 32'h0);
        check("irq_pin5_masked", {31'd0, irq}, 32'd0);
        gpio_in = 8'h04;
        wait_cycles(SYNC + 2);
        @(posedge clk);
        #1;
        gpio_in = 8'h24;
        wait_cycles(SYNC - 1);
        wb_xfer("w1c_race", 3'd4, 32'h20, 1'b1, 32'd0);
        wb_xfer("pend_race", 3'd4, 32'd0, 1'b0, IRQ_EN ? 32'h20 : 32'h0);
        wb_xfer("w1c_plain", 3'd4, 32'h20, 1'b1, 32'd0);
        wb_xfer("pend_plain", 3'd4, 32'd0, 1'b0, 32'h0);

        // Reset during a write, pins held high throughout
        wb_xfer("wr_out_ff", 3'd0, 32'hFF, 1'b1, 32'd0);
        check("gpio_ff", 32'(gpio_out), 32'hFF);
        gpio_in = 8'hFF;
        wb_adr  = 3'd0;
        wb_dat  = 32'h0000_0055;
        wb_we   = 1'b1;
        wb_stb  = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_gpio", 32'(gpio_out), 32'd0);
        check("rst_mid_ack", {31'd0, wb_ack}, 32'd0);
        wb_stb = 1'b0;
        wb_we  = 1'b0;
        wait_cycles(2);
        check("rst_hold_ack", {31'd0, wb_ack}, 32'd0);
        rst_n = 1'b1;
        wait_cycles(SYNC + 4);
        wb_xfer("pend_after_rst", 3'd4, 32'd0, 1'b0, 32'h0);
        check("irq_after_rst", {31'd0, irq}, 32'd0);
        wb_xfer("in_after_rst", 3'd2, 32'd0, 1'b0, 32'hFF);
        wb_xfer("out_after_rst", 3'd0, 32'd0, 1'b0, 32'h0);

        // Full mask, all pins toggled
        wb_xfer("wr_mask_ff", 3'd3, 32'hFF, 1'b1, 32'd0);
        wb_xfer("rd_mask_ff", 3'd3, 32'd0, 1'b0, IRQ_EN ? 32'hFF : 32'h0);
        gpio_in = 8'h00;
        wait_cycles(SYNC + 2);
        gpio_in = 8'hFF;
        wait_cycles(SYNC + 3);
        check("irq_all", {31'd0, irq}, {31'd0, IRQ_EN});
        wb_xfer("pend_all", 3'd4, 32'd0, 1'b0, IRQ_EN ? 32'hFF : 32'h0);
        wb_xfer("rd_adr6", 3'd6, 32'd0, 1'b0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
